// File: rtl/mux_scan_sequencer_pkg.sv
// mux_scan_sequencer_pkg: shared state encoding and channel geometry for the scan sequencer
package mux_scan_sequencer_pkg;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, HOLD} state_t;
endpackage

// File: rtl/mux_scan_sequencer_if.sv
// mux_scan_sequencer_if: control, mux-side and downstream handshake signals of the scan sequencer
interface mux_scan_sequencer_if;
    import mux_scan_sequencer_pkg::*;
    logic             start;
    logic             continuous;
    logic [SEL_W-1:0] sel;
    logic             mux_y;
    logic [NUM_CH-1:0] data;
    logic             valid;
    logic             ready;
    logic             busy;
    logic             start_drop;
    modport master (input start, continuous, mux_y, ready, output sel, data, valid, busy, start_drop);
    modport slave  (output start, continuous, mux_y, ready, input sel, data, valid, busy, start_drop);
endinterface

// File: rtl/mux_scan_sequencer_settle_timer.sv
// settle_timer: loadable down-counter flagging the last settle cycle of a channel
module settle_timer #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic done
);
    localparam int CW = ($clog2(SETTLE_CYCLES + 1) > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    logic [CW-1:0] cnt;
    // reload at each channel start, count down while settling, never below zero
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= CW'(SETTLE_CYCLES);
        else if (dec && cnt != '0)
            cnt <= cnt - CW'(1);
    assign done = cnt == CW'(1);
endmodule

// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: steps the 4:1 mux select, samples Y per channel and hands the word downstream
module mux_scan_sequencer
    import mux_scan_sequencer_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mux_scan_sequencer_if.master  bus
);
    localparam state_t FIRST = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
    state_t     state;
    logic [3:1] shadow;
    logic       load;
    logic       done;
    // a fresh settle period begins whenever sel moves to a new channel
    always_comb
        load = (state == IDLE && bus.start) ||
               (state == SAMPLE && bus.sel != 2'd3) ||
               (state == HOLD && bus.ready && bus.continuous);
    settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load),
        .dec  (state == SETTLE),
        .done (done)
    );
    // scan FSM with registered select, word, handshake and status outputs
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state          <= IDLE;
            bus.sel        <= '0;
            bus.data       <= '0;
            bus.valid      <= 1'b0;
            bus.busy       <= 1'b0;
            bus.start_drop <= 1'b0;
            shadow         <= '0;
        end else begin
            if (bus.start && state != IDLE)
                bus.start_drop <= 1'b1;
            case (state)
                IDLE:
                    if (bus.start) begin
                        bus.sel  <= '0;
                        bus.busy <= 1'b1;
                        state    <= FIRST;
                    end
                SETTLE:
                    if (done)
                        state <= SAMPLE;
                SAMPLE:
                    if (bus.sel != 2'd3) begin
                        shadow[~bus.sel] <= bus.mux_y;
                        bus.sel          <= bus.sel + 2'd1;
                        state            <= FIRST;
                    end else begin
                        bus.data  <= {shadow, bus.mux_y};
                        bus.valid <= 1'b1;
                        state     <= HOLD;
                    end
                HOLD:
                    if (bus.ready) begin
                        bus.valid <= 1'b0;
                        bus.sel   <= '0;
                        bus.busy  <= bus.continuous;
                        state     <= bus.continuous ? FIRST : IDLE;
                    end
                default: state <= IDLE;
            endcase
        end
endmodule
